// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record used by regfile_ctrl.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;

  // Register 0 is hardwired to zero, so writes to it are accepted but dropped.
  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    return addr != REG_ZERO;
  endfunction
endpackage

// File: rtl/rf_wr_arbiter.sv
// Single-write-port arbiter: core has priority, debug is forced through after
// STARVE_LIMIT consecutive refusals.
module rf_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic core_we,
  input  logic dbg_req,
  output logic core_grant,
  output logic dbg_grant,
  output logic core_stall
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             at_limit;

  assign at_limit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_reg <= '0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (dbg_grant)
      starve_cnt_next = '0;
    else if (dbg_req && !at_limit)
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
  end

  // Grants are suppressed while reset is held so nothing commits during reset.
  always_comb begin
    dbg_grant  = 1'b0;
    core_grant = 1'b0;
    core_stall = 1'b0;
    if (!rst) begin
      dbg_grant  = dbg_req && (!core_we || at_limit);
      core_grant = core_we && !dbg_grant;
      core_stall = core_we && dbg_grant;
    end
  end
endmodule

// File: rtl/regfile_ctrl.sv
// 32x32 register file with one arbitrated write port (core vs debug) and two
// combinational read ports. Optional same-cycle forwarding: define REGFILE_BYPASS_EN.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [XLEN-1:0]       rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]       rd_data_b,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_waddr,
  input  logic [XLEN-1:0]       core_wdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]       dbg_wdata,
  output logic                  dbg_ack
);
  logic    core_grant, dbg_grant;
  wr_req_t wr;
  logic    wr_commit;
  logic [XLEN-1:0] regs [NUM_REGS];

  rf_wr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .core_we    (core_we),
    .dbg_req    (dbg_req),
    .core_grant (core_grant),
    .dbg_grant  (dbg_grant),
    .core_stall (core_stall)
  );

  assign dbg_ack = dbg_grant;

  always_comb begin
    wr = '0;
    if (core_grant) begin
      wr.en   = 1'b1;
      wr.addr = core_waddr;
      wr.data = core_wdata;
    end else if (dbg_grant) begin
      wr.en   = 1'b1;
      wr.addr = dbg_addr;
      wr.data = dbg_wdata;
    end
  end

  assign wr_commit = wr.en && is_writable(wr.addr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [XLEN-1:0] r_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)
            r_reg <= '0;
          else if (wr_commit && wr.addr == REG_ADDR_W'(gi))
            r_reg <= wr.data;
        end
        assign regs[gi] = r_reg;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  // wr_commit already excludes address 0, so register 0 still reads as zero.
  assign rd_data_a = (wr_commit && wr.addr == rd_addr_a) ? wr.data : regs[rd_addr_a];
  assign rd_data_b = (wr_commit && wr.addr == rd_addr_b) ? wr.data : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif
endmodule

// File: tb/tb_regfile_ctrl.sv
// Scenario-per-task bench for regfile_ctrl; read expectations flow through a scoreboard queue.
module tb_regfile_ctrl;
  logic        clk, rst;
  logic [4:0]  rd_addr_a, rd_addr_b, core_waddr, dbg_addr;
  logic [31:0] rd_data_a, rd_data_b, core_wdata, dbg_wdata;
  logic        core_we, core_stall, dbg_req, dbg_ack;

  logic [31:0] exp_q [$];
  logic [31:0] model [32];
  logic [31:0] exp_v;
  int n_tests = 0;
  int n_fail  = 0;

  regfile_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_we = 1'b0; core_waddr = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0;   dbg_wdata = '0;
    rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic test_reset();
    core_we = 1'b1; core_waddr = 5'd1; core_wdata = 32'hFFFF_FFFF;
    dbg_req = 1'b1; dbg_addr = 5'd2;   dbg_wdata = 32'hEEEE_EEEE;
    rst = 1'b1;
    #2;
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hs: got ack/stall %b expected 00", {dbg_ack, core_stall});
    end
    cyc(); cyc();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
      exp_q.push_back(model[a]); exp_q.push_back(model[31 - a]);
      #1;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (rd_data_a !== exp_v) begin
        n_fail++;
        $display("FAIL reset_rd_a[%0d]: got %h expected %h", a, rd_data_a, exp_v);
      end
      exp_v = exp_q.pop_front();
      n_tests++;
      if (rd_data_b !== exp_v) begin
        n_fail++;
        $display("FAIL reset_rd_b[%0d]: got %h expected %h", 31 - a, rd_data_b, exp_v);
      end
    end
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle_hs: got ack/stall %b expected 00", {dbg_ack, core_stall});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_zero_reg();
    cyc();
    core_we = 1'b1; core_waddr = 5'd0; core_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_wr_hs: got ack/stall %b expected 00", {dbg_ack, core_stall});
    end
    cyc();
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'h1234;
    rd_addr_a = 5'd0; exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL zero_rd: got %h expected %h", rd_data_a, exp_v);
    end
    model[5] = 32'h1234;
    cyc();
    core_we = 1'b0;
    dbg_req = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
    rd_addr_a = 5'd5; exp_q.push_back(32'h1234);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL r5_rd: got %h expected %h", rd_data_a, exp_v);
    end
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL dbg_zero_hs: got ack/stall %b expected 10", {dbg_ack, core_stall});
    end
    cyc();
    dbg_req = 1'b0;
    rd_addr_b = 5'd0; exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL dbg_zero_rd: got %h expected %h", rd_data_b, exp_v);
    end
    $display("[TB] test_zero_reg done");
  endtask

  task automatic test_starvation();
    logic exp_g;
    cyc();
    dbg_req = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hA5A5_A5A5;
    for (int k = 1; k <= 5; k++) begin
      core_we = 1'b1; core_waddr = 5'(9 + k); core_wdata = 32'hC000_0000 | k;
      exp_g = (k == 5);
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== {exp_g, exp_g}) begin
        n_fail++;
        $display("FAIL starve_hs[%0d]: got ack/stall %b expected %b", k, {dbg_ack, core_stall}, {exp_g, exp_g});
      end
      if (exp_g) model[7] = dbg_wdata;
      else       model[core_waddr] = core_wdata;
      cyc();
    end
    dbg_req = 1'b0;
    #1;
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL starve_retry_hs: got ack/stall %b expected 00", {dbg_ack, core_stall});
    end
    model[core_waddr] = core_wdata;
    cyc();
    core_we = 1'b0;
    for (int a = 7; a <= 14; a++) begin
      rd_addr_a = 5'(a); exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (rd_data_a !== exp_v) begin
        n_fail++;
        $display("FAIL starve_rd[%0d]: got %h expected %h", a, rd_data_a, exp_v);
      end
    end
    n_tests++;
    if (model[7] !== 32'hA5A5_A5A5 || model[14] !== 32'hC000_0005) begin
      n_fail++;
      $display("FAIL starve_model: got %h/%h expected a5a5a5a5/c0000005", model[7], model[14]);
    end
    $display("[TB] test_starvation done");
  endtask

  task automatic test_starve_hold();
    logic exp_g;
    cyc();
    core_we = 1'b1; core_waddr = 5'd16; core_wdata = 32'h1;
    dbg_addr = 5'd8; dbg_wdata = 32'h88;
    for (int j = 0; j < 4; j++) begin
      dbg_req = (j < 2);
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_hs[%0d]: got ack/stall %b expected 00", j, {dbg_ack, core_stall});
      end
      cyc();
    end
    dbg_req = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      exp_g = (j == 3);
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== {exp_g, exp_g}) begin
        n_fail++;
        $display("FAIL hold_resume_hs[%0d]: got ack/stall %b expected %b", j, {dbg_ack, core_stall}, {exp_g, exp_g});
      end
      if (exp_g) model[8] = 32'h88;
      cyc();
    end
    model[16] = 32'h1;
    idle_inputs();
    rd_addr_a = 5'd8; rd_addr_b = 5'd16;
    exp_q.push_back(model[8]); exp_q.push_back(model[16]);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL hold_rd8: got %h expected %h", rd_data_a, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL hold_rd16: got %h expected %h", rd_data_b, exp_v);
    end
    $display("[TB] test_starve_hold done");
  endtask

  task automatic test_idle_core();
    logic exp_g;
    for (int j = 0; j < 2; j++) begin
      cyc();
      core_we = 1'b0;
      dbg_req = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h99 + j;
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== 2'b10) begin
        n_fail++;
        $display("FAIL idle_hs[%0d]: got ack/stall %b expected 10", j, {dbg_ack, core_stall});
      end
      model[9] = dbg_wdata;
    end
    cyc();
    dbg_addr = 5'd12; dbg_wdata = 32'h12C;
    core_we = 1'b1; core_waddr = 5'd17; core_wdata = 32'h17;
    for (int k = 1; k <= 5; k++) begin
      exp_g = (k == 5);
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== {exp_g, exp_g}) begin
        n_fail++;
        $display("FAIL idle_then_busy_hs[%0d]: got ack/stall %b expected %b", k, {dbg_ack, core_stall}, {exp_g, exp_g});
      end
      if (exp_g) model[12] = 32'h12C;
      else       model[17] = 32'h17;
      cyc();
    end
    idle_inputs();
    rd_addr_a = 5'd9; rd_addr_b = 5'd12;
    exp_q.push_back(32'h9A); exp_q.push_back(32'h12C);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL idle_rd9: got %h expected %h", rd_data_a, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL idle_rd12: got %h expected %h", rd_data_b, exp_v);
    end
    $display("[TB] test_idle_core done");
  endtask

  task automatic test_bypass();
    cyc();
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h11;
    cyc();
    model[3] = 32'h11;
    core_wdata = 32'h55;
    rd_addr_a = 5'd3; rd_addr_b = 5'd3;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h55); exp_q.push_back(32'h55);
`else
    exp_q.push_back(32'h11); exp_q.push_back(32'h11);
`endif
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_a: got %h expected %h", rd_data_a, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_b: got %h expected %h", rd_data_b, exp_v);
    end
    model[3] = 32'h55;
    cyc();
    core_waddr = 5'd0; core_wdata = 32'hFFFF;
    rd_addr_a = 5'd0; exp_q.push_back(32'h0); exp_q.push_back(32'h55);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_zero: got %h expected %h", rd_data_a, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_after: got %h expected %h", rd_data_b, exp_v);
    end
    cyc();
    idle_inputs();
    $display("[TB] test_bypass done");
  endtask

  task automatic test_reset_mid();
    logic exp_g;
    cyc();
    dbg_req = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h77;
    for (int k = 0; k < 3; k++) begin
      core_we = 1'b1; core_waddr = 5'(20 + k); core_wdata = 32'hB0 + k;
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_pre_hs[%0d]: got ack/stall %b expected 00", k, {dbg_ack, core_stall});
      end
      cyc();
    end
    core_waddr = 5'd23; core_wdata = 32'hB3;
    rst = 1'b1;
    rd_addr_a = 5'd20; exp_q.push_back(32'h0);
    #1;
    n_tests++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_rst_hs: got ack/stall %b expected 00", {dbg_ack, core_stall});
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL mid_rst_clear: got %h expected %h", rd_data_a, exp_v);
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    core_waddr = 5'd24; core_wdata = 32'hC4;
    for (int k = 1; k <= 5; k++) begin
      exp_g = (k == 5);
      #1;
      n_tests++;
      if ({dbg_ack, core_stall} !== {exp_g, exp_g}) begin
        n_fail++;
        $display("FAIL mid_post_hs[%0d]: got ack/stall %b expected %b", k, {dbg_ack, core_stall}, {exp_g, exp_g});
      end
      if (exp_g) model[7] = 32'h77;
      else       model[24] = 32'hC4;
      cyc();
    end
    idle_inputs();
    rd_addr_a = 5'd23; rd_addr_b = 5'd7;
    exp_q.push_back(model[23]); exp_q.push_back(model[7]);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_a !== exp_v) begin
      n_fail++;
      $display("FAIL mid_discard: got %h expected %h", rd_data_a, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rd_data_b !== exp_v) begin
      n_fail++;
      $display("FAIL mid_dbg_rd: got %h expected %h", rd_data_b, exp_v);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_zero_reg();
    test_starvation();
    test_starve_hold();
    test_idle_core();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a debug write may be refused before it is forced through.
REQ-002 SHALL have port clk  in  1  the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rd_addr_a  in  5  read port A address.
REQ-005 SHALL have port rd_data_a  out  32  read port A data.
REQ-006 SHALL have port rd_addr_b  in  5  read port B address.
REQ-007 SHALL have port rd_data_b  out  32  read port B data.
REQ-008 SHALL have port core_we  in  1  core writeback request.
REQ-009 SHALL have port core_waddr  in  5  core writeback address.
REQ-010 SHALL have port core_wdata  in  32  core writeback data.
REQ-011 SHALL have port core_stall  out  1  core write refused this cycle; core holds its request.
REQ-012 SHALL have port dbg_req  in  1  debug/loader write request, held until acknowledged.
REQ-013 SHALL have port dbg_addr  in  5  debug write address.
REQ-014 SHALL have port dbg_wdata  in  32  debug write data.
REQ-015 SHALL have port dbg_ack  out  1  debug write commits at this cycle's edge.

Function
REQ-016 SHALL hold 32 x 32-bit registers; reads are combinational from current state.
REQ-017 SHALL return 32'h0 on any read of address 0, regardless of any write history.
REQ-018 SHALL complete writes to address 0 with a normal handshake and leave state unchanged.
REQ-019 SHALL commit at most one write per cycle.
REQ-020 SHALL grant core when core_we=1 and starve_cnt<STARVE_LIMIT; dbg_ack=0 and the debug request waits.
REQ-021 SHALL grant debug when dbg_req=1 and (core_we=0 or starve_cnt==STARVE_LIMIT); dbg_ack=1 that cycle.
REQ-022 SHALL set core_stall=1 exactly when core_we=1 and debug is granted; otherwise core_stall=0.
REQ-023 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle dbg_req=1 and not granted, clear it on debug grant, and hold it when dbg_req=0.
REQ-024 SHALL keep dbg_ack and core_stall combinational from the current inputs and starve_cnt, with no additional latency.
REQ-025 SHALL make a committed write visible on the read ports from the cycle after commit (no same-cycle forwarding unless REQ-029 applies).

Reset
REQ-026 SHALL, while rst=1, clear all registers to 0, set starve_cnt to 0, and force dbg_ack=0 and core_stall=0.
REQ-027 SHALL discard any write request present in the cycle rst asserts; the requester re-issues it after reset.

Configuration
REQ-028 SHALL support the macro REGFILE_BYPASS_EN.
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, forward the granted write data to a read port whose address equals the granted nonzero write address in the same cycle.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return pre-write contents in the commit cycle.

Structure
REQ-031 SHALL take REG_ZERO (5'd0), REG_ADDR_W (5), and XLEN (32) from shared package regfile_pkg.
REQ-032 SHALL place the grant and starvation logic in a sub-module rf_wr_arbiter; the storage array stays in regfile_ctrl.

Verification
REQ-033 SHALL cover reset: rst pulse, then read of all 32 addresses -> every read returns 0; dbg_ack=0; core_stall=0.
REQ-034 SHALL cover the zero register: core writes 32'hDEADBEEF to address 0, then reads A=0 -> returns 0; a core write of 32'h1234 to address 5 reads back 32'h1234 on the next cycle.
REQ-035 SHALL cover starvation: core_we=1 every cycle with dbg_req=1 (addr 7, data 32'hA5A5A5A5), STARVE_LIMIT=4 -> dbg_ack=1 and core_stall=1 on the 5th cycle; register 7 = 32'hA5A5A5A5 afterwards.
REQ-036 SHALL cover an idle core: dbg_req=1 with core_we=0 -> dbg_ack=1 in the same cycle; starve_cnt stays 0.
REQ-037 SHALL cover bypass: write 32'h55 to address 3 with rd_addr_a=3 -> rd_data_a=32'h55 in the commit cycle with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-038 SHALL cover reset mid-operation: rst asserted while starve_cnt=3 -> after release, the debug request needs a full 4 refused cycles before it is forced through.
